// File: rtl/y86_seq_ctrl_if.sv
// Bus bundle for the Y86 SEQ sequencer.
// master: core top level / testbench side; drives run, step_mode, pc_new and
//         the stage status flags, and observes pc, stage_en, stat, busy,
//         stopped and the performance counters.
// slave:  the sequencer itself (y86_seq_ctrl).
interface y86_seq_ctrl_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned CNT_W  = 32
) ();

  logic              run;
  logic              step_mode;
  logic [ADDR_W-1:0] pc_new;
  logic              halt;
  logic              invalid_instr;
  logic              memory_error;
  logic              mem_ready;

  logic [ADDR_W-1:0] pc;
  logic [5:0]        stage_en;
  logic [2:0]        stat;
  logic              busy;
  logic              stopped;
  logic [CNT_W-1:0]  cycle_count;
  logic [CNT_W-1:0]  instr_count;

  modport master (
    output run, step_mode, pc_new, halt, invalid_instr, memory_error, mem_ready,
    input  pc, stage_en, stat, busy, stopped, cycle_count, instr_count
  );

  modport slave (
    input  run, step_mode, pc_new, halt, invalid_instr, memory_error, mem_ready,
    output pc, stage_en, stat, busy, stopped, cycle_count, instr_count
  );

endinterface

// File: rtl/y86_seq_ctrl.sv
// Multi-cycle sequencer and architectural-state owner for the Y86 SEQ core.
// Steps one instruction through fetch, decode, execute, memory, write-back
// and PC update; owns the PC and the Y86 status code; stops on halt, invalid
// instruction, address error or data-memory timeout.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - y86_seq_ctrl_if.slave:
//          in : run, step_mode, pc_new, halt, invalid_instr, memory_error, mem_ready
//          out: pc, stage_en {P,W,M,E,D,F}, stat, busy, stopped,
//               cycle_count, instr_count
//
// Build option: define SEQ_PERF_CNT_EN to implement the saturating
// cycle/instruction counters; otherwise both outputs are tied to zero.
module y86_seq_ctrl #(
  parameter int unsigned       ADDR_W      = 64,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int unsigned       CNT_W       = 32,
  parameter int unsigned       MEM_TIMEOUT = 16
) (
  input logic             clk,
  input logic             rst,
  y86_seq_ctrl_if.slave   bus
);

  localparam logic [2:0] StatAok = 3'd1;
  localparam logic [2:0] StatHlt = 3'd2;
  localparam logic [2:0] StatAdr = 3'd3;
  localparam logic [2:0] StatIns = 3'd4;

  // Wait counter only needs to reach MEM_TIMEOUT-1.
  localparam int unsigned WaitW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExecute,
    StMemory,
    StWriteback,
    StPcupd,
    StStopped
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [2:0]        stat_q, stat_d;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic [5:0]        stage_en_q, stage_en_d;
  logic              busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      stat_q     <= StatAok;
      wait_q     <= '0;
      stage_en_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      stat_q     <= stat_d;
      wait_q     <= wait_d;
      stage_en_q <= stage_en_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    stat_d     = stat_q;
    wait_d     = '0;  // cleared everywhere but MEMORY, so entry always starts at 0
    stage_en_d = '0;

    unique case (state_q)
      StIdle: begin
        if (bus.run) state_d = StFetch;
      end
      StFetch: begin
        if (bus.memory_error) begin
          stat_d  = StatAdr;
          state_d = StStopped;
        end else if (bus.invalid_instr) begin
          stat_d  = StatIns;
          state_d = StStopped;
        end else if (bus.halt) begin
          stat_d  = StatHlt;
          state_d = StStopped;
        end else begin
          state_d = StDecode;
        end
      end
      StDecode:  state_d = StExecute;
      StExecute: state_d = StMemory;
      StMemory: begin
        if (bus.memory_error) begin
          stat_d  = StatAdr;
          state_d = StStopped;
        end else if (bus.mem_ready) begin
          state_d = StWriteback;
        end else if ((MEM_TIMEOUT != 0) && (wait_q == WaitW'(MEM_TIMEOUT - 1))) begin
          // MEM_TIMEOUT cycles spent in MEMORY without a ready.
          stat_d  = StatAdr;
          state_d = StStopped;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StWriteback: state_d = StPcupd;
      StPcupd: begin
        pc_d    = bus.pc_new;
        state_d = bus.step_mode ? StIdle : StFetch;
      end
      StStopped: state_d = StStopped;
      default:   state_d = StIdle;
    endcase

    // Registered decode of the next state, so stage_en tracks state_q.
    unique case (state_d)
      StFetch:     stage_en_d = 6'b000001;
      StDecode:    stage_en_d = 6'b000010;
      StExecute:   stage_en_d = 6'b000100;
      StMemory:    stage_en_d = 6'b001000;
      StWriteback: stage_en_d = 6'b010000;
      StPcupd:     stage_en_d = 6'b100000;
      default:     stage_en_d = 6'b000000;
    endcase
  end

  assign busy         = (state_q != StIdle) && (state_q != StStopped);
  assign bus.busy     = busy;
  assign bus.stopped  = (state_q == StStopped);
  assign bus.pc       = pc_q;
  assign bus.stat     = stat_q;
  assign bus.stage_en = stage_en_q;

`ifdef SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] instr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      if (busy && (cycle_q != {CNT_W{1'b1}})) cycle_q <= cycle_q + 1'b1;
      if ((state_q == StPcupd) && (instr_q != {CNT_W{1'b1}})) instr_q <= instr_q + 1'b1;
    end
  end

  assign bus.cycle_count = cycle_q;
  assign bus.instr_count = instr_q;
`else
  assign bus.cycle_count = {CNT_W{1'b0}};
  assign bus.instr_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_y86_seq_ctrl.sv
module tb_y86_seq_ctrl;

  localparam logic [63:0] ResetPc = 64'h100;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  y86_seq_ctrl_if #(.ADDR_W(64), .CNT_W(32)) bus ();

  y86_seq_ctrl #(
    .ADDR_W     (64),
    .RESET_PC   (ResetPc),
    .CNT_W      (32),
    .MEM_TIMEOUT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.run           = 1'b0;
    bus.step_mode     = 1'b0;
    bus.pc_new        = '0;
    bus.halt          = 1'b0;
    bus.invalid_instr = 1'b0;
    bus.memory_error  = 1'b0;
    bus.mem_ready     = 1'b1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Issue a run pulse; returns in the first FETCH cycle.
  task automatic start();
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    #2;
    checks++;
    if (bus.pc !== ResetPc) begin
      errors++; $display("FAIL reset_pc: got %h want %h", bus.pc, ResetPc);
    end
    checks++;
    if (bus.stat !== 3'd1) begin
      errors++; $display("FAIL reset_stat: got %0d want 1", bus.stat);
    end
    checks++;
    if (bus.stage_en !== 6'b0 || bus.busy !== 1'b0 || bus.stopped !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: stage_en=%b busy=%b stopped=%b want 0/0/0",
               bus.stage_en, bus.busy, bus.stopped);
    end
    checks++;
    if (bus.cycle_count !== 32'd0 || bus.instr_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_cnt: cyc=%0d ins=%0d want 0/0", bus.cycle_count, bus.instr_count);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (bus.stage_en !== 6'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: stage_en=%b busy=%b want 0/0", bus.stage_en, bus.busy);
    end
  endtask

  task automatic test_nop_halt();
    logic [5:0] exp_en;
    logic [31:0] exp_cyc;
    logic [31:0] exp_ins;
`ifdef SEQ_PERF_CNT_EN
    exp_cyc = 32'd7;
    exp_ins = 32'd1;
`else
    exp_cyc = 32'd0;
    exp_ins = 32'd0;
`endif
    do_reset();
    bus.pc_new = ResetPc + 64'd1;
    start();
    for (int i = 0; i < 6; i++) begin
      exp_en = 6'b000001 << i;
      checks++;
      if (bus.stage_en !== exp_en || bus.busy !== 1'b1 || bus.pc !== ResetPc) begin
        errors++;
        $display("FAIL nop_stage%0d: stage_en=%b busy=%b pc=%h want %b/1/%h",
                 i, bus.stage_en, bus.busy, bus.pc, exp_en, ResetPc);
      end
      tick();
    end
    checks++;
    if (bus.stage_en !== 6'b000001 || bus.pc !== ResetPc + 64'd1) begin
      errors++;
      $display("FAIL nop_refetch: stage_en=%b pc=%h want 000001/%h",
               bus.stage_en, bus.pc, ResetPc + 64'd1);
    end
    bus.halt = 1'b1;
    tick();
    bus.halt = 1'b0;
    checks++;
    if (bus.stat !== 3'd2 || bus.stopped !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL halt_stop: stat=%0d stopped=%b busy=%b want 2/1/0",
               bus.stat, bus.stopped, bus.busy);
    end
    checks++;
    if (bus.pc !== ResetPc + 64'd1 || bus.stage_en !== 6'b0) begin
      errors++;
      $display("FAIL halt_pc: pc=%h stage_en=%b want %h/0", bus.pc, bus.stage_en,
               ResetPc + 64'd1);
    end
    checks++;
    if (bus.cycle_count !== exp_cyc || bus.instr_count !== exp_ins) begin
      errors++;
      $display("FAIL halt_cnt: cyc=%0d ins=%0d want %0d/%0d", bus.cycle_count,
               bus.instr_count, exp_cyc, exp_ins);
    end
    // STOPPED is terminal: run is ignored and counters freeze.
    bus.run = 1'b1;
    tick();
    tick();
    bus.run = 1'b0;
    checks++;
    if (bus.stopped !== 1'b1 || bus.stage_en !== 6'b0 || bus.cycle_count !== exp_cyc) begin
      errors++;
      $display("FAIL stop_hold: stopped=%b stage_en=%b cyc=%0d want 1/0/%0d",
               bus.stopped, bus.stage_en, bus.cycle_count, exp_cyc);
    end
  endtask

  task automatic test_priority();
    do_reset();
    start();
    bus.invalid_instr = 1'b1;
    bus.halt          = 1'b1;
    tick();
    clear_inputs();
    checks++;
    if (bus.stat !== 3'd4 || bus.stopped !== 1'b1 || bus.stage_en !== 6'b0) begin
      errors++;
      $display("FAIL prio_ins: stat=%0d stopped=%b stage_en=%b want 4/1/0",
               bus.stat, bus.stopped, bus.stage_en);
    end
    do_reset();
    start();
    bus.memory_error  = 1'b1;
    bus.invalid_instr = 1'b1;
    tick();
    clear_inputs();
    checks++;
    if (bus.stat !== 3'd3 || bus.stopped !== 1'b1) begin
      errors++;
      $display("FAIL prio_adr: stat=%0d stopped=%b want 3/1", bus.stat, bus.stopped);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    bus.pc_new = 64'h200;
    bus.mem_ready = 1'b0;
    start();
    tick();  // DECODE
    tick();  // EXECUTE
    tick();  // MEMORY 1
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.stage_en !== 6'b001000) begin
        errors++; $display("FAIL memwait_m%0d: stage_en=%b want 001000", i + 1, bus.stage_en);
      end
      tick();
    end
    // Fourth MEMORY cycle: ready arrives just before the timeout would fire.
    checks++;
    if (bus.stage_en !== 6'b001000 || bus.stopped !== 1'b0) begin
      errors++;
      $display("FAIL memwait_m4: stage_en=%b stopped=%b want 001000/0",
               bus.stage_en, bus.stopped);
    end
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    checks++;
    if (bus.stage_en !== 6'b010000) begin
      errors++; $display("FAIL memwait_wb: stage_en=%b want 010000", bus.stage_en);
    end
    tick();
    tick();
    checks++;
    if (bus.stage_en !== 6'b000001 || bus.pc !== 64'h200) begin
      errors++;
      $display("FAIL memwait_next: stage_en=%b pc=%h want 000001/200", bus.stage_en, bus.pc);
    end
  endtask

  // Continues from the FETCH left by test_mem_wait, mem_ready held low.
  task automatic test_mem_timeout();
    logic saw_wb;
    saw_wb = 1'b0;
    bus.pc_new = 64'h300;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (bus.stage_en[4]) saw_wb = 1'b1;
    end
    checks++;
    if (bus.stat !== 3'd3 || bus.stopped !== 1'b1 || bus.stage_en !== 6'b0) begin
      errors++;
      $display("FAIL timeout_stop: stat=%0d stopped=%b stage_en=%b want 3/1/0",
               bus.stat, bus.stopped, bus.stage_en);
    end
    checks++;
    if (saw_wb !== 1'b0 || bus.pc !== 64'h200) begin
      errors++;
      $display("FAIL timeout_nowb: saw_wb=%b pc=%h want 0/200", saw_wb, bus.pc);
    end
    do_reset();
    start();
    tick();
    tick();
    bus.mem_ready    = 1'b1;
    bus.memory_error = 1'b1;
    tick();  // MEMORY: error beats ready
    tick();
    clear_inputs();
    checks++;
    if (bus.stat !== 3'd3 || bus.stopped !== 1'b1 || bus.pc !== ResetPc) begin
      errors++;
      $display("FAIL memerr_stop: stat=%0d stopped=%b pc=%h want 3/1/%h",
               bus.stat, bus.stopped, bus.pc, ResetPc);
    end
  endtask

  task automatic test_step_mode();
    do_reset();
    bus.step_mode = 1'b1;
    bus.pc_new    = 64'd10;
    start();
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.stopped !== 1'b0 || bus.stage_en !== 6'b0 ||
        bus.pc !== 64'd10) begin
      errors++;
      $display("FAIL step_idle: busy=%b stopped=%b stage_en=%b pc=%0d want 0/0/0/10",
               bus.busy, bus.stopped, bus.stage_en, bus.pc);
    end
    tick();
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.stage_en !== 6'b0) begin
      errors++;
      $display("FAIL step_wait: busy=%b stage_en=%b want 0/0", bus.busy, bus.stage_en);
    end
    start();
    checks++;
    if (bus.stage_en !== 6'b000001 || bus.busy !== 1'b1 || bus.pc !== 64'd10) begin
      errors++;
      $display("FAIL step_rerun: stage_en=%b busy=%b pc=%0d want 000001/1/10",
               bus.stage_en, bus.busy, bus.pc);
    end
  endtask

  task automatic test_async_reset();
    // From a stopped ADR state, reset must act between clock edges.
    do_reset();
    bus.memory_error = 1'b1;
    start();
    tick();
    clear_inputs();
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.stat !== 3'd1 || bus.stopped !== 1'b0) begin
      errors++;
      $display("FAIL arst_stat: stat=%0d stopped=%b want 1/0", bus.stat, bus.stopped);
    end
    tick();
    rst = 1'b0;
    bus.pc_new = 64'h40;
    start();
    for (int i = 0; i < 6; i++) tick();  // second instruction FETCH, pc=0x40
    tick();
    tick();  // EXECUTE
    checks++;
    if (bus.stage_en !== 6'b000100 || bus.pc !== 64'h40) begin
      errors++;
      $display("FAIL arst_pre: stage_en=%b pc=%h want 000100/40", bus.stage_en, bus.pc);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.pc !== ResetPc || bus.stat !== 3'd1 || bus.stage_en !== 6'b0 ||
        bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL arst_mid: pc=%h stat=%0d stage_en=%b busy=%b want %h/1/0/0",
               bus.pc, bus.stat, bus.stage_en, bus.busy, ResetPc);
    end
    checks++;
    if (bus.cycle_count !== 32'd0 || bus.instr_count !== 32'd0) begin
      errors++;
      $display("FAIL arst_cnt: cyc=%0d ins=%0d want 0/0", bus.cycle_count, bus.instr_count);
    end
    tick();
    rst = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    test_reset();
    test_nop_halt();
    test_priority();
    test_mem_wait();
    test_mem_timeout();
    test_step_mode();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
